// File: rtl/tm_tape_spi_responder.sv
// tm_tape_spi_responder
// SPI mode-0 responder backed by a small on-chip byte array. The initiator
// reads (CMD_READ) or writes (CMD_WRITE) sequential bursts starting at a
// 16-bit big-endian address; only the low MEM_BITS address bits are used.
// A host side-port preloads and inspects the array.
// All SPI pins are oversampled on clk through 2-FF synchronisers.
// MEM_BITS must be between 1 and 8.

module tm_tape_spi_responder #(
    parameter int          MEM_BITS  = 4,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_sck,
    input  logic                spi_cs,
    input  logic                spi_mosi,
    output logic                spi_miso,
    input  logic                host_wr_en_i,
    input  logic [MEM_BITS-1:0] host_addr_i,
    input  logic [7:0]          host_wr_data_i,
    output logic [7:0]          host_rd_data_o,
    output logic                busy_o,
    output logic                conflict_o
);

    localparam int                DEPTH    = 1 << MEM_BITS;
    localparam logic [MEM_BITS-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        IGNORE
    } state_t;

    state_t state_q, state_d;

    // synchroniser stages plus one history flop for edge detection
    logic sck_meta, sck_sync, sck_prev;
    logic cs_meta, cs_sync, cs_prev;
    logic mosi_meta, mosi_sync;

    logic sck_rise, sck_fall, cs_fall, cs_rise;

    logic [6:0]          shift;      // last seven sampled bits
    logic [7:0]          byte_in;    // shift plus the bit arriving this edge
    logic [3:0]          bit_cnt;
    logic                is_wr;
    logic [MEM_BITS-1:0] addr;
    logic [7:0]          out_sh;
    logic                miso_q;
    logic [7:0]          wr_byte;
    logic                commit_pend;
    logic                busy_q;
    logic                conflict_q;

    logic [7:0] mem [DEPTH];

    // Synchronise the SPI pins; CS idles high so reset leaves it deasserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= spi_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            cs_meta   <= spi_cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;
    assign cs_fall  = ~cs_sync & cs_prev;
    assign cs_rise  = cs_sync & ~cs_prev;
    assign byte_in  = {shift, mosi_sync};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: CS rising always wins and aborts whatever was in flight
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = CMD;
                CMD: begin
                    if (sck_rise && bit_cnt == 4'd7) begin
                        if (byte_in == CMD_READ || byte_in == CMD_WRITE) state_d = ADDR;
                        else                                              state_d = IGNORE;
                    end
                end
                ADDR: if (sck_rise && bit_cnt == 4'd15) state_d = is_wr ? WR : RD;
                default: state_d = state_q;
            endcase
        end
    end

    // Bit/byte datapath: shift in on synced SCK rise, shift out on synced SCK fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift       <= '0;
            bit_cnt     <= '0;
            is_wr       <= 1'b0;
            addr        <= '0;
            out_sh      <= '0;
            miso_q      <= 1'b0;
            wr_byte     <= '0;
            commit_pend <= 1'b0;
        end else begin
            commit_pend <= 1'b0;
            // the commit itself lands in the array this cycle; step to the next byte
            if (commit_pend) addr <= addr + ADDR_ONE;
            if (state_q != RD) miso_q <= 1'b0;

            if (cs_rise || (state_q == IDLE && cs_fall)) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else begin
                case (state_q)
                    CMD: if (sck_rise) begin
                        shift <= byte_in[6:0];
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            is_wr   <= (byte_in == CMD_WRITE);
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ADDR: if (sck_rise) begin
                        shift   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 4'd1;   // 15 wraps to 0 for the data phase
                        // upper address bits fall off the end of the shifter: aliasing
                        if (bit_cnt == 4'd15) addr <= byte_in[MEM_BITS-1:0];
                    end
                    WR: if (sck_rise) begin
                        shift <= byte_in[6:0];
                        if (bit_cnt == 4'd7) begin
                            bit_cnt     <= '0;
                            wr_byte     <= byte_in;
                            commit_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RD: if (sck_fall) begin
                        if (bit_cnt == 4'd0) begin
                            // fetch at byte start so earlier writes in this burst are seen
                            miso_q  <= mem[addr][7];
                            out_sh  <= {mem[addr][6:0], 1'b0};
                            bit_cnt <= 4'd1;
                        end else begin
                            miso_q <= out_sh[7];
                            out_sh <= {out_sh[6:0], 1'b0};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                addr    <= addr + ADDR_ONE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte array: SPI commit has priority over a same-cycle host write
    always_ff @(posedge clk) begin
        if (commit_pend)       mem[addr]        <= wr_byte;
        else if (host_wr_en_i) mem[host_addr_i] <= host_wr_data_i;
    end

    // Status flags: busy follows synced CS, conflict flags a dropped host write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= ~cs_sync;
            conflict_q <= commit_pend & host_wr_en_i;
        end
    end

    assign spi_miso       = (state_q == RD) & miso_q;
    assign busy_o         = busy_q;
    assign conflict_o     = conflict_q;
    assign host_rd_data_o = mem[host_addr_i];

endmodule

// File: tb/tb_tm_tape_spi_responder.sv
// Bench for tm_tape_spi_responder: bit-banged SPI initiator plus a plain
// array model of the backing store, exercised with directed and random bursts.

module tb_tm_tape_spi_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sck, spi_cs, spi_mosi, spi_miso;
    logic       host_wr_en_i;
    logic [3:0] host_addr_i;
    logic [7:0] host_wr_data_i, host_rd_data_o;
    logic       busy_o, conflict_o;

    int vecs = 0;
    int errs = 0;

    logic [7:0] model [16];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    always #5 clk = ~clk;

    tm_tape_spi_responder #(.MEM_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .host_wr_en_i(host_wr_en_i), .host_addr_i(host_addr_i),
        .host_wr_data_i(host_wr_data_i), .host_rd_data_o(host_rd_data_o),
        .busy_o(busy_o), .conflict_o(conflict_o)
    );

    // ---------------- initiator primitives ----------------
    task automatic spi_bit(input logic b, output logic r);
        @(posedge clk); #1 spi_mosi = b;
        repeat (4) @(posedge clk);
        #1 r = spi_miso; spi_sck = 1'b1;
        repeat (4) @(posedge clk);
        #1 spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_begin();
        @(posedge clk); #1 spi_cs = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic cs_end();
        repeat (5) @(posedge clk);
        #1 spi_cs = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    // write burst of tx_q at a; the model applies the same bytes with wrap
    task automatic spi_write(input logic [15:0] a);
        logic [7:0] d;
        cs_begin();
        spi_byte(8'h02, d); spi_byte(a[15:8], d); spi_byte(a[7:0], d);
        foreach (tx_q[i]) spi_byte(tx_q[i], d);
        cs_end();
        foreach (tx_q[i]) model[(int'(a) + i) % 16] = tx_q[i];
    endtask

    task automatic spi_read(input logic [15:0] a, input int n);
        logic [7:0] d;
        rx_q.delete();
        cs_begin();
        spi_byte(8'h03, d); spi_byte(a[15:8], d); spi_byte(a[7:0], d);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'($urandom), d);
            rx_q.push_back(d);
        end
        cs_end();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1 host_wr_en_i = 1'b1; host_addr_i = a; host_wr_data_i = d;
        @(posedge clk); #1 host_wr_en_i = 1'b0;
        model[a] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        host_wr_en_i = 1'b0; host_addr_i = '0; host_wr_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({spi_miso, busy_o, conflict_o} !== 3'b000) begin
            errs++; $display("FAIL reset_outputs: got %b want 000", {spi_miso, busy_o, conflict_o});
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({spi_miso, busy_o, conflict_o} !== 3'b000) begin
            errs++; $display("FAIL post_reset_outputs: got %b want 000", {spi_miso, busy_o, conflict_o});
        end
        for (int i = 0; i < 16; i++) host_write(4'(i), 8'($urandom));
    endtask

    task automatic test_busy();
        int n = 0;
        @(posedge clk); #1 spi_cs = 1'b0;
        while (busy_o !== 1'b1 && n < 10) begin
            @(posedge clk); #1 n++;
        end
        vecs++;
        if (n < 2 || n > 3) begin
            errs++; $display("FAIL busy_latency: got %0d clk want 2..3", n);
        end
        #1 spi_cs = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        vecs++;
        if (busy_o !== 1'b0) begin
            errs++; $display("FAIL busy_release: got %b want 0", busy_o);
        end
    endtask

    task automatic test_write_read();
        tx_q = '{8'hA5};
        spi_write(16'h0005);
        spi_read(16'h0005, 1);
        vecs++;
        if (rx_q[0] !== 8'hA5) begin
            errs++; $display("FAIL write_read_miso: got %h want a5", rx_q[0]);
        end
        host_addr_i = 4'd5; #1;
        vecs++;
        if (host_rd_data_o !== 8'hA5) begin
            errs++; $display("FAIL write_read_host: got %h want a5", host_rd_data_o);
        end
    endtask

    task automatic test_wrap();
        host_write(4'd15, 8'h11);
        host_write(4'd0, 8'h22);
        spi_read(16'h000F, 2);
        vecs++;
        if (rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin
            errs++; $display("FAIL wrap_read: got %h %h want 11 22", rx_q[0], rx_q[1]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic r;
        d = ~model[3];
        cs_begin();
        spi_byte(8'h02, d); spi_byte(8'h00, d); spi_byte(8'h03, d);
        d = ~model[3];
        for (int i = 7; i >= 3; i--) spi_bit(d[i], r);
        cs_end();
        host_addr_i = 4'd3; #1;
        vecs++;
        if (host_rd_data_o !== model[3]) begin
            errs++; $display("FAIL abort_array: got %h want %h", host_rd_data_o, model[3]);
        end
        vecs++;
        if (busy_o !== 1'b0) begin
            errs++; $display("FAIL abort_idle_busy: got %b want 0", busy_o);
        end
        spi_read(16'h0003, 1);
        vecs++;
        if (rx_q[0] !== model[3]) begin
            errs++; $display("FAIL abort_next_txn: got %h want %h", rx_q[0], model[3]);
        end
    endtask

    task automatic test_ignore();
        logic [7:0] d;
        int ones = 0;
        cs_begin();
        spi_byte(8'h9F, d);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'($urandom), d);
            ones += $countones(d);
        end
        cs_end();
        vecs++;
        if (ones != 0) begin
            errs++; $display("FAIL ignore_miso: got %0d one-bits want 0", ones);
        end
        for (int i = 0; i < 16; i++) begin
            host_addr_i = 4'(i); #1;
            vecs++;
            if (host_rd_data_o !== model[i]) begin
                errs++; $display("FAIL ignore_array[%0d]: got %h want %h", i, host_rd_data_o, model[i]);
            end
        end
        spi_read(16'h0009, 1);
        vecs++;
        if (rx_q[0] !== model[9]) begin
            errs++; $display("FAIL ignore_next_txn: got %h want %h", rx_q[0], model[9]);
        end
    endtask

    task automatic test_conflict();
        logic [7:0] d;
        logic r;
        logic c;
        d = 8'h3C;
        cs_begin();
        spi_byte(8'h02, d); spi_byte(8'h00, d); spi_byte(8'h07, d);
        d = 8'h3C;
        for (int i = 7; i >= 1; i--) spi_bit(d[i], r);
        // last bit by hand so the host strobe lines up with the commit clock
        @(posedge clk); #1 spi_mosi = d[0];
        repeat (4) @(posedge clk);
        #1 spi_sck = 1'b1;
        repeat (3) @(posedge clk);
        #1 host_wr_en_i = 1'b1; host_addr_i = 4'd7; host_wr_data_i = 8'hC3;
        @(posedge clk);
        #1 host_wr_en_i = 1'b0;
        c = conflict_o;
        vecs++;
        if (c !== 1'b1) begin
            errs++; $display("FAIL conflict_pulse: got %b want 1", c);
        end
        @(posedge clk); #1;
        vecs++;
        if (conflict_o !== 1'b0) begin
            errs++; $display("FAIL conflict_one_cycle: got %b want 0", conflict_o);
        end
        repeat (2) @(posedge clk);
        #1 spi_sck = 1'b0;
        cs_end();
        model[7] = 8'h3C;
        host_addr_i = 4'd7; #1;
        vecs++;
        if (host_rd_data_o !== 8'h3C) begin
            errs++; $display("FAIL conflict_winner: got %h want 3c", host_rd_data_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic r;
        // reset during the address phase of a read
        cs_begin();
        spi_byte(8'h03, d); spi_byte(8'h00, d);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        vecs++;
        if ({spi_miso, busy_o} !== 2'b00) begin
            errs++; $display("FAIL reset_mid_outputs: got %b want 00", {spi_miso, busy_o});
        end
        spi_cs = 1'b1; spi_sck = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        spi_read(16'h0000, 1);
        vecs++;
        if (rx_q[0] !== model[0]) begin
            errs++; $display("FAIL reset_mid_read: got %h want %h", rx_q[0], model[0]);
        end
        // reset during a write data byte: nothing may land
        cs_begin();
        spi_byte(8'h02, d); spi_byte(8'h00, d); spi_byte(8'h08, d);
        d = ~model[8];
        for (int i = 7; i >= 1; i--) spi_bit(d[i], r);
        @(posedge clk); #1 rst_n = 1'b0;
        spi_cs = 1'b1; spi_sck = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        host_addr_i = 4'd8; #1;
        vecs++;
        if (host_rd_data_o !== model[8]) begin
            errs++; $display("FAIL reset_mid_write: got %h want %h", host_rd_data_o, model[8]);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        int n;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) host_write(4'($urandom), 8'($urandom));
            tx_q.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            a = 16'($urandom);   // upper bits random: exercises aliasing
            spi_write(a);
            a = 16'($urandom);
            n = $urandom_range(1, 5);
            spi_read(a, n);
            for (int i = 0; i < n; i++) begin
                vecs++;
                if (rx_q[i] !== model[(int'(a) + i) % 16]) begin
                    errs++;
                    $display("FAIL random_read it%0d byte%0d addr %h: got %h want %h",
                             it, i, a, rx_q[i], model[(int'(a) + i) % 16]);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            host_addr_i = 4'(i); #1;
            vecs++;
            if (host_rd_data_o !== model[i]) begin
                errs++; $display("FAIL final_array[%0d]: got %h want %h", i, host_rd_data_o, model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_busy();
        test_write_read();
        test_wrap();
        test_abort();
        test_ignore();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
